tlu_trigger_data_receiver: RTL and testbench

//  Sequences the TLU trigger-number handshake: on a start flag from the TLU controller FSM it drives the TLU

---
 rtl/tlu_pkg.sv | 20 ++
 rtl/tlu_sync_ff.sv | 32 +++
 rtl/tlu_trigger_data_receiver.sv | 144 ++++++++++++++
 tb/tb_tlu_trigger_data_receiver.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/tlu_pkg.sv
// Shared definitions for the TLU trigger-number receiver: FSM encoding, word format
// and the rule that maps NUM_BITS to a bit count.
package tlu_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_CCK_HIGH = 2'd1,
    ST_CCK_LOW  = 2'd2,
    ST_STORE    = 2'd3
  } tlu_state_t;

  localparam logic TLU_WORD_MARKER  = 1'b1;
  localparam int   TLU_NUMBER_WIDTH = 31;

  // A NUM_BITS value of zero requests the full trigger-number width.
  function automatic logic [4:0] effective_bits(input logic [4:0] num_bits);
    return (num_bits == 5'd0) ? 5'd31 : num_bits;
  endfunction

endpackage

// File: rtl/tlu_sync_ff.sv
// Multi-stage reset-to-0 synchronizer that brings the asynchronous TLU data line into the CLK domain.
module tlu_sync_ff #(
  parameter int STAGES = 2
) (
  input  logic CLK,
  input  logic RESET,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] sync_reg;

  genvar gi;
  generate
    for (gi = 0; gi < STAGES; gi++) begin : g_stage
      if (gi == 0) begin : g_first
        always_ff @(posedge CLK or posedge RESET) begin
          if (RESET) sync_reg[gi] <= 1'b0;
          else       sync_reg[gi] <= d;
        end
      end else begin : g_next
        always_ff @(posedge CLK or posedge RESET) begin
          if (RESET) sync_reg[gi] <= 1'b0;
          else       sync_reg[gi] <= sync_reg[gi-1];
        end
      end
    end
  endgenerate

  assign q = sync_reg[STAGES-1];

endmodule

// File: rtl/tlu_trigger_data_receiver.sv
// Clocks the trigger number out of the TLU bit by bit on CCK, assembles it LSB first and
// writes one marked word to the readout FIFO.
module tlu_trigger_data_receiver
  import tlu_pkg::*;
#(
  parameter int HALF_PERIOD = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        TLU_RECEIVE_DATA_FLAG,
  input  logic        ABORT,
  input  logic        TLU_DATA,
  input  logic [4:0]  NUM_BITS,
  output logic        TLU_CLOCK,
  output logic        TLU_DATA_RECEIVED_FLAG,
  output logic [30:0] TRIGGER_NUMBER,
  input  logic        FIFO_FULL,
  output logic        FIFO_WRITE,
  output logic [31:0] FIFO_DATA,
  output logic        BUSY
);

  localparam logic [7:0] HALF_LAST = 8'(HALF_PERIOD - 1);

  tlu_state_t                  state_reg;
  logic [7:0]                  half_cnt_reg;
  logic [4:0]                  bit_cnt_reg;
  logic [4:0]                  n_reg;
  logic [TLU_NUMBER_WIDTH-1:0] shift_reg;
  logic [TLU_NUMBER_WIDTH-1:0] shift_next;
  logic [TLU_NUMBER_WIDTH-1:0] trigger_number_reg;
  logic [31:0]                 fifo_data_reg;
  logic                        tlu_clock_reg;
  logic                        fifo_write_reg;
  logic                        received_reg;
  logic                        data_sync;
  logic                        half_last;
  logic                        bit_last;

  tlu_sync_ff #(
    .STAGES(SYNC_STAGES)
  ) u_data_sync (
    .CLK  (CLK),
    .RESET(RESET),
    .d    (TLU_DATA),
    .q    (data_sync)
  );

  always_comb begin
    shift_next = shift_reg;
    shift_next[bit_cnt_reg] = data_sync;
  end

  assign half_last = (half_cnt_reg == HALF_LAST);
  assign bit_last  = (5'(bit_cnt_reg + 5'd1) == n_reg);

  // FIFO_FULL is judged on the edge that launches the write strobe, so the strobe,
  // the received pulse and the new trigger number all leave the block registered.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_reg          <= ST_IDLE;
      half_cnt_reg       <= 8'd0;
      bit_cnt_reg        <= 5'd0;
      n_reg              <= 5'd0;
      shift_reg          <= '0;
      trigger_number_reg <= '0;
      fifo_data_reg      <= 32'd0;
      tlu_clock_reg      <= 1'b0;
      fifo_write_reg     <= 1'b0;
      received_reg       <= 1'b0;
    end else begin
      fifo_write_reg <= 1'b0;
      received_reg   <= 1'b0;
      if (ABORT && (state_reg != ST_IDLE)) begin
        state_reg     <= ST_IDLE;
        half_cnt_reg  <= 8'd0;
        tlu_clock_reg <= 1'b0;
      end else begin
        case (state_reg)
          ST_IDLE: begin
            if (TLU_RECEIVE_DATA_FLAG && !ABORT) begin
              n_reg         <= effective_bits(NUM_BITS);
              shift_reg     <= '0;
              bit_cnt_reg   <= 5'd0;
              half_cnt_reg  <= 8'd0;
              tlu_clock_reg <= 1'b1;
              state_reg     <= ST_CCK_HIGH;
            end
          end
          ST_CCK_HIGH: begin
            if (half_last) begin
              half_cnt_reg  <= 8'd0;
              tlu_clock_reg <= 1'b0;
              state_reg     <= ST_CCK_LOW;
            end else begin
              half_cnt_reg <= half_cnt_reg + 8'd1;
            end
          end
          ST_CCK_LOW: begin
            if (half_last) begin
              half_cnt_reg <= 8'd0;
              shift_reg    <= shift_next;
              bit_cnt_reg  <= bit_cnt_reg + 5'd1;
              if (bit_last) begin
                state_reg <= ST_STORE;
                if (!FIFO_FULL) begin
                  fifo_write_reg     <= 1'b1;
                  received_reg       <= 1'b1;
                  trigger_number_reg <= shift_next;
                  fifo_data_reg      <= {TLU_WORD_MARKER, shift_next};
                end
              end else begin
                tlu_clock_reg <= 1'b1;
                state_reg     <= ST_CCK_HIGH;
              end
            end else begin
              half_cnt_reg <= half_cnt_reg + 8'd1;
            end
          end
          ST_STORE: begin
            if (fifo_write_reg) begin
              state_reg <= ST_IDLE;
            end else if (!FIFO_FULL) begin
              fifo_write_reg     <= 1'b1;
              received_reg       <= 1'b1;
              trigger_number_reg <= shift_reg;
              fifo_data_reg      <= {TLU_WORD_MARKER, shift_reg};
            end
          end
          default: state_reg <= ST_IDLE;
        endcase
      end
    end
  end

  assign TLU_CLOCK              = tlu_clock_reg;
  assign TLU_DATA_RECEIVED_FLAG = received_reg;
  assign TRIGGER_NUMBER         = trigger_number_reg;
  assign FIFO_WRITE             = fifo_write_reg;
  assign FIFO_DATA              = fifo_data_reg;
  assign BUSY                   = (state_reg != ST_IDLE);

endmodule

// File: tb/tb_tlu_trigger_data_receiver.sv
// Scoreboard bench for the TLU trigger receiver: a TLU model answers CCK rises with data bits,
// expected FIFO words are queued at start time and checked when FIFO_WRITE appears.
module tb_tlu_trigger_data_receiver;

  localparam int HALF = 2;

  typedef struct {
    logic [31:0] data;
    int          cyc;
  } exp_t;

  logic        clk = 1'b0;
  logic        RESET = 1'b1;
  logic        TLU_RECEIVE_DATA_FLAG = 1'b0;
  logic        ABORT = 1'b0;
  logic        TLU_DATA = 1'b0;
  logic [4:0]  NUM_BITS = 5'd0;
  logic        FIFO_FULL = 1'b0;
  logic        TLU_CLOCK;
  logic        TLU_DATA_RECEIVED_FLAG;
  logic [30:0] TRIGGER_NUMBER;
  logic        FIFO_WRITE;
  logic [31:0] FIFO_DATA;
  logic        BUSY;

  int   tests = 0;
  int   fails = 0;
  int   cyc = 0;
  exp_t exp_q[$];

  // TLU side: bit index follows CCK rises since the current transfer started
  logic [30:0] tlu_word = 31'd0;
  int          tlu_rises = 0;
  int          tlu_base = 0;

  int   cck_count = 0;
  int   width_err = 0;
  int   high_len = 0;
  logic prev_cck = 1'b0;

  tlu_trigger_data_receiver #(
    .HALF_PERIOD(HALF),
    .SYNC_STAGES(2)
  ) dut (
    .CLK                   (clk),
    .RESET                 (RESET),
    .TLU_RECEIVE_DATA_FLAG (TLU_RECEIVE_DATA_FLAG),
    .ABORT                 (ABORT),
    .TLU_DATA              (TLU_DATA),
    .NUM_BITS              (NUM_BITS),
    .TLU_CLOCK             (TLU_CLOCK),
    .TLU_DATA_RECEIVED_FLAG(TLU_DATA_RECEIVED_FLAG),
    .TRIGGER_NUMBER        (TRIGGER_NUMBER),
    .FIFO_FULL             (FIFO_FULL),
    .FIFO_WRITE            (FIFO_WRITE),
    .FIFO_DATA             (FIFO_DATA),
    .BUSY                  (BUSY)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge TLU_CLOCK) begin
    int idx;
    idx = tlu_rises - tlu_base;
    TLU_DATA = (idx >= 0 && idx < 31) ? tlu_word[idx] : 1'b0;
    tlu_rises++;
  end

  always @(negedge clk) begin
    if (TLU_CLOCK && !prev_cck) cck_count++;
    if (TLU_CLOCK) begin
      high_len++;
    end else begin
      if (prev_cck && high_len != HALF) width_err++;
      high_len = 0;
    end
    prev_cck = TLU_CLOCK;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every FIFO write must match the oldest queued expectation
  always @(negedge clk) begin
    exp_t e;
    if (!RESET && FIFO_WRITE) begin
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_write: got data 0x%08h expected no write (cycle %0d)", FIFO_DATA, cyc);
      end else begin
        e = exp_q.pop_front();
        $display("[TB] write data=0x%08h cycle=%0d", FIFO_DATA, cyc);
        check("fifo_data", FIFO_DATA, e.data);
        check("write_cycle", 32'(cyc), 32'(e.cyc));
        check("received_flag", {31'd0, TLU_DATA_RECEIVED_FLAG}, 32'd1);
        check("trigger_number", {1'b0, TRIGGER_NUMBER}, {1'b0, e.data[30:0]});
      end
    end else if (!RESET && TLU_DATA_RECEIVED_FLAG) begin
      tests++;
      fails++;
      $display("FAIL received_without_write: got 1 expected 0 (cycle %0d)", cyc);
    end
  end

  // Issues a start pulse; returns at the negedge of the first CCK-high cycle.
  task automatic start_xfer(input logic [4:0] nb, input logic [30:0] word, input bit push,
                            input int extra, output int k);
    int n;
    exp_t e;
    n = (nb == 5'd0) ? 31 : int'(nb);
    @(negedge clk);
    k = cyc;
    tlu_word = word;
    tlu_base = tlu_rises;
    if (push) begin
      e.data = {1'b1, word};
      e.cyc  = k + 1 + 2 * HALF * n + extra;
      exp_q.push_back(e);
    end
    NUM_BITS = nb;
    TLU_RECEIVE_DATA_FLAG = 1'b1;
    @(negedge clk);
    TLU_RECEIVE_DATA_FLAG = 1'b0;
  endtask

  task automatic wait_drain(input int bound);
    for (int i = 0; i < bound && exp_q.size() != 0; i++) @(negedge clk);
    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL drain_timeout: got %0d pending expected 0 (cycle %0d)", exp_q.size(), cyc);
      exp_q.delete();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    int cb;
    int wb;
    int i;

    // Reset state
    repeat (3) @(negedge clk);
    check("reset_tlu_clock", {31'd0, TLU_CLOCK}, 32'd0);
    check("reset_busy", {31'd0, BUSY}, 32'd0);
    check("reset_fifo_write", {31'd0, FIFO_WRITE}, 32'd0);
    check("reset_trigger", {1'b0, TRIGGER_NUMBER}, 32'd0);
    check("reset_fifo_data", FIFO_DATA, 32'd0);
    RESET = 1'b0;
    repeat (2) @(negedge clk);

    // 15 bits of 0x1234: write lands 61 cycles after the start pulse
    cb = cck_count; wb = width_err;
    start_xfer(5'd15, 31'h1234, 1'b1, 0, k);
    check("first_cck_rise", {31'd0, TLU_CLOCK}, 32'd1);
    check("busy_in_xfer", {31'd0, BUSY}, 32'd1);
    wait_drain(200);
    @(negedge clk);
    check("cck_count_15", 32'(cck_count - cb), 32'd15);
    check("cck_width_15", 32'(width_err - wb), 32'd0);
    check("idle_after_15", {31'd0, BUSY}, 32'd0);

    // NUM_BITS=0 means 31 bits, all ones
    cb = cck_count; wb = width_err;
    start_xfer(5'd0, 31'h7FFF_FFFF, 1'b1, 0, k);
    wait_drain(300);
    @(negedge clk);
    check("cck_count_31", 32'(cck_count - cb), 32'd31);
    check("cck_width_31", 32'(width_err - wb), 32'd0);

    // FIFO full while the word is ready: stall in STORE, write follows the release
    cb = cck_count;
    FIFO_FULL = 1'b1;
    start_xfer(5'd4, 31'hA, 1'b1, 11, k);
    while (cyc < k + 26) @(negedge clk);
    check("stall_cck_low", {31'd0, TLU_CLOCK}, 32'd0);
    check("stall_busy", {31'd0, BUSY}, 32'd1);
    @(negedge clk);
    FIFO_FULL = 1'b0;
    wait_drain(50);
    check("stall_cck_count", 32'(cck_count - cb), 32'd4);

    // Abort after the fifth CCK: no write, trigger number kept
    cb = cck_count;
    start_xfer(5'd8, 31'h5A, 1'b0, 0, k);
    for (i = 0; i < 100 && (cck_count - cb) < 5; i++) @(negedge clk);
    check("abort_reached_5th", 32'(cck_count - cb), 32'd5);
    ABORT = 1'b1;
    @(negedge clk);
    check("abort_cck_low", {31'd0, TLU_CLOCK}, 32'd0);
    check("abort_busy", {31'd0, BUSY}, 32'd0);
    ABORT = 1'b0;
    repeat (60) @(negedge clk);
    check("abort_trigger_kept", {1'b0, TRIGGER_NUMBER}, 32'h0000_000A);
    start_xfer(5'd8, 31'hC3, 1'b1, 0, k);
    wait_drain(100);

    // A second start pulse during a transfer is ignored
    cb = cck_count;
    start_xfer(5'd6, 31'h2D, 1'b1, 0, k);
    repeat (5) @(negedge clk);
    NUM_BITS = 5'd2;
    TLU_RECEIVE_DATA_FLAG = 1'b1;
    @(negedge clk);
    TLU_RECEIVE_DATA_FLAG = 1'b0;
    wait_drain(100);
    repeat (30) @(negedge clk);
    check("restart_cck_count", 32'(cck_count - cb), 32'd6);

    // Asynchronous reset in the middle of a CCK high phase
    cb = cck_count;
    start_xfer(5'd10, 31'h3FF, 1'b0, 0, k);
    for (i = 0; i < 100 && !((cck_count - cb) >= 3 && TLU_CLOCK); i++) @(negedge clk);
    check("rst_in_high", {31'd0, TLU_CLOCK}, 32'd1);
    RESET = 1'b1;
    #1;
    check("rst_tlu_clock", {31'd0, TLU_CLOCK}, 32'd0);
    check("rst_busy", {31'd0, BUSY}, 32'd0);
    check("rst_fifo_write", {31'd0, FIFO_WRITE}, 32'd0);
    check("rst_trigger", {1'b0, TRIGGER_NUMBER}, 32'd0);
    @(negedge clk);
    RESET = 1'b0;
    repeat (2) @(negedge clk);

    // Recovery after reset
    start_xfer(5'd3, 31'h5, 1'b1, 0, k);
    wait_drain(50);
    repeat (5) @(negedge clk);
    check("queue_empty", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
